// File: rtl/mux_arb_stream_pkg.sv
// Shared definitions for the stream multiplexer/arbiter.
// Holds only the selection-mode encodings; every other constant is local to its block.
package mux_arb_stream_pkg;

  // Selection policy for mux_arb_stream.MODE
  localparam int MUX_MODE_SEL = 0;  // channel chosen by the sel input
  localparam int MUX_MODE_RR  = 1;  // channel chosen by round-robin arbitration

endpackage : mux_arb_stream_pkg

// File: rtl/mux_arb_stream_rr_arbiter.sv
// Round-robin grant logic.
// The search starts at the channel after the most recent winner, so a
// requester that holds req high is served within N grants.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  logic found;

  // Pick the first requester at or after (last+1) mod N, wrapping to channel 0
  always_comb begin
    // NOTE: every output gets a default before the loop; without it a path
    // that finds no requester would infer a latch.
    grant       = '0;
    found       = 1'b0;
    grant_valid = |req;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(last) + 1 + i) % N]) begin
        grant = SELW'((int'(last) + 1 + i) % N);
        found = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/mux_arb_stream.sv
// N-to-1 stream multiplexer with a single registered output slot.
// Channel selection is either fixed (sel input) or round-robin, chosen by MODE.
// Inputs see a zero-cycle ready path; data reaches the output one cycle later.
module mux_arb_stream
  import mux_arb_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = MUX_MODE_SEL,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [SELW-1:0]   sel,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_chan
);

  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  if (MODE == MUX_MODE_RR) begin : g_rr
    logic [SELW-1:0] last;

    rr_arbiter #(
      .N    (N),
      .SELW (SELW)
    ) u_rr_arbiter (
      .req         (in_valid),
      .last        (last),
      .grant       (grant),
      .grant_valid (grant_valid)
    );

    // Remember the most recent winner; it only moves when a word is actually taken
    always_ff @(posedge clk) begin
      if (rst) begin
        last <= SELW'(N - 1);
      end else if (xfer) begin
        last <= grant;
      end
    end
  end else begin : g_sel
    // Fixed select: an out-of-range sel matches no channel and grants nothing
    always_comb begin
      grant       = sel;
      grant_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (sel == SELW'(k)) begin
          grant_valid = in_valid[k];
        end
      end
    end
  end

  // Output slot can take a word when empty or when its word leaves this cycle
  always_comb begin
    load_en    = !out_valid || out_ready;
    in_ready   = '0;
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant == SELW'(k)) begin
        in_ready[k] = !rst && load_en && grant_valid;
        grant_data  = in_data[k*WIDTH +: WIDTH];
      end
    end
    xfer = |(in_valid & in_ready);
  end

  // Output register: load on transfer, empty on drain, hold while stalled
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule : mux_arb_stream

// File: tb/tb_mux_arb_stream.sv
// Scoreboard bench for mux_arb_stream: fixed-select (N=4), round-robin (N=4)
// and fixed-select with an out-of-range select (N=3).
module tb_mux_arb_stream;
  import mux_arb_stream_pkg::*;

  typedef struct packed {
    logic [1:0]  chan;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  // DUT a: fixed select, N=4
  logic         a_rst;
  logic [127:0] a_in_data;
  logic [3:0]   a_in_valid, a_in_ready;
  logic [1:0]   a_sel, a_out_chan;
  logic [31:0]  a_out_data;
  logic         a_out_valid, a_out_ready;

  // DUT b: round-robin, N=4
  logic         b_rst;
  logic [127:0] b_in_data;
  logic [3:0]   b_in_valid, b_in_ready;
  logic [1:0]   b_sel, b_out_chan;
  logic [31:0]  b_out_data;
  logic         b_out_valid, b_out_ready;

  // DUT c: fixed select, N=3
  logic         c_rst;
  logic [95:0]  c_in_data;
  logic [2:0]   c_in_valid, c_in_ready;
  logic [1:0]   c_sel, c_out_chan;
  logic [31:0]  c_out_data;
  logic         c_out_valid, c_out_ready;

  mux_arb_stream #(.WIDTH(32), .N(4), .MODE(MUX_MODE_SEL)) u_dut_a (
    .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_chan(a_out_chan)
  );

  mux_arb_stream #(.WIDTH(32), .N(4), .MODE(MUX_MODE_RR)) u_dut_b (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_chan(b_out_chan)
  );

  mux_arb_stream #(.WIDTH(32), .N(3), .MODE(MUX_MODE_SEL)) u_dut_c (
    .clk(clk), .rst(c_rst), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_chan(c_out_chan)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int ch, input logic [31:0] d);
    exp_t e;
    e.chan = 2'(ch);
    e.data = d;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a word is consumed at the next edge when valid and ready are both high
  always @(negedge clk) begin
    if (!a_rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected: got chan %0d data %0h expected no word", a_out_chan, a_out_data);
      end else begin
        ea = qa.pop_front();
        check("a_out_chan", 64'(a_out_chan), 64'(ea.chan));
        check("a_out_data", 64'(a_out_data), 64'(ea.data));
      end
    end
  end

  always @(negedge clk) begin
    if (!b_rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected: got chan %0d data %0h expected no word", b_out_chan, b_out_data);
      end else begin
        eb = qb.pop_front();
        check("b_out_chan", 64'(b_out_chan), 64'(eb.chan));
        check("b_out_data", 64'(b_out_data), 64'(eb.data));
      end
    end
  end

  always @(negedge clk) begin
    if (!c_rst && c_out_valid && c_out_ready) begin
      if (qc.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL c_unexpected: got chan %0d data %0h expected no word", c_out_chan, c_out_data);
      end else begin
        ec = qc.pop_front();
        check("c_out_chan", 64'(c_out_chan), 64'(ec.chan));
        check("c_out_data", 64'(c_out_data), 64'(ec.data));
      end
    end
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_in_valid = 4'hF; b_in_valid = 4'hF; c_in_valid = 3'h7;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    a_sel = 2'd0; b_sel = 2'd0; c_sel = 2'd0;
    for (int k = 0; k < 4; k++) begin
      a_in_data[k*32 +: 32] = 32'hA0 + 32'(k);
      b_in_data[k*32 +: 32] = 32'hB0 + 32'(k);
    end
    for (int k = 0; k < 3; k++) begin
      c_in_data[k*32 +: 32] = 32'hC0 + 32'(k);
    end

    // Reset held two cycles with every channel valid
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_a_in_ready",  64'(a_in_ready),  64'd0);
      check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
      check("rst_a_out_data",  64'(a_out_data),  64'd0);
      check("rst_a_out_chan",  64'(a_out_chan),  64'd0);
      check("rst_b_in_ready",  64'(b_in_ready),  64'd0);
      check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
      check("rst_c_in_ready",  64'(c_in_ready),  64'd0);
      check("rst_c_out_valid", 64'(c_out_valid), 64'd0);
    end

    // Fixed select sweep 0..3, one word per cycle
    a_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_sel = 2'(k);
      #1;
      check("a_sweep_in_ready", 64'(a_in_ready), 64'(1 << k));
      qa.push_back(mk(k, 32'hA0 + 32'(k)));
      tick();
    end

    // Load 1234 on channel 2, then stall three cycles
    a_in_data[2*32 +: 32] = 32'h1234;
    a_sel = 2'd2;
    #1;
    check("a_load2_in_ready", 64'(a_in_ready), 64'b0100);
    qa.push_back(mk(2, 32'h1234));
    tick();
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("a_stall_in_ready",  64'(a_in_ready),  64'd0);
      check("a_stall_out_data",  64'(a_out_data),  64'h1234);
      check("a_stall_out_valid", 64'(a_out_valid), 64'd1);
      check("a_stall_out_chan",  64'(a_out_chan),  64'd2);
      tick();
    end

    // Release: same-cycle drain of 1234 and load from channel 1
    a_sel = 2'd1;
    a_out_ready = 1'b1;
    #1;
    check("a_release_in_ready", 64'(a_in_ready), 64'b0010);
    qa.push_back(mk(1, 32'hA1));
    tick();
    check("a_after_release_chan", 64'(a_out_chan), 64'd1);
    check("a_after_release_data", 64'(a_out_data), 64'hA1);
    a_in_valid = 4'h0;
    tick();
    check("a_drain_out_valid", 64'(a_out_valid), 64'd0);
    check("a_drain_hold_data", 64'(a_out_data),  64'hA1);
    check("a_drain_hold_chan", 64'(a_out_chan),  64'd1);

    // Round-robin: all valid -> 0,1,2,3,0,1 starting the first cycle out of reset
    b_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("b_rr_in_ready", 64'(b_in_ready), 64'(1 << (i % 4)));
      qb.push_back(mk(i % 4, 32'hB0 + 32'(i % 4)));
      tick();
    end
    // Only channel 2 -> last becomes 2
    b_in_valid = 4'b0100;
    #1;
    check("b_only2_in_ready", 64'(b_in_ready), 64'b0100);
    qb.push_back(mk(2, 32'hB2));
    tick();
    // Channels 0 and 3: from last=2 grant 3, then wrap to 0
    b_in_valid = 4'b1001;
    #1;
    check("b_skip_in_ready", 64'(b_in_ready), 64'b1000);
    qb.push_back(mk(3, 32'hB3));
    tick();
    check("b_wrap_in_ready", 64'(b_in_ready), 64'b0001);
    qb.push_back(mk(0, 32'hB0));
    tick();
    // Load channel 1, stall it, then reset: the word is discarded
    b_in_valid = 4'b0010;
    #1;
    check("b_pre_stall_in_ready", 64'(b_in_ready), 64'b0010);
    tick();
    b_out_ready = 1'b0;
    #1;
    check("b_stall_out_valid", 64'(b_out_valid), 64'd1);
    check("b_stall_out_chan",  64'(b_out_chan),  64'd1);
    check("b_stall_in_ready",  64'(b_in_ready),  64'd0);
    b_rst = 1'b1;
    b_in_valid = 4'hF;
    b_out_ready = 1'b1;
    #1;
    check("b_rst_in_ready", 64'(b_in_ready), 64'd0);
    tick();
    b_rst = 1'b0;
    #1;
    check("b_post_rst_out_valid", 64'(b_out_valid), 64'd0);
    check("b_post_rst_out_data",  64'(b_out_data),  64'd0);
    // last was reset to N-1, so channel 0 wins again
    check("b_post_rst_in_ready",  64'(b_in_ready),  64'b0001);
    qb.push_back(mk(0, 32'hB0));
    tick();
    b_in_valid = 4'h0;
    tick();
    check("b_end_out_valid", 64'(b_out_valid), 64'd0);

    // N=3: sel=3 grants nothing; current word drains and out_valid falls
    c_rst = 1'b0;
    #1;
    check("c_sel0_in_ready", 64'(c_in_ready), 64'b001);
    qc.push_back(mk(0, 32'hC0));
    tick();
    c_sel = 2'd3;
    #1;
    check("c_sel3_in_ready",  64'(c_in_ready),  64'd0);
    check("c_sel3_out_valid", 64'(c_out_valid), 64'd1);
    tick();
    check("c_drain_out_valid", 64'(c_out_valid), 64'd0);
    check("c_drain_hold_data", 64'(c_out_data),  64'hC0);
    check("c_drain_in_ready",  64'(c_in_ready),  64'd0);
    tick();
    check("c_idle_out_valid", 64'(c_out_valid), 64'd0);

    tick();
    check("qa_empty", 64'(qa.size()), 64'd0);
    check("qb_empty", 64'(qb.size()), 64'd0);
    check("qc_empty", 64'(qc.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_arb_stream
